aes128_encrypt_core: RTL and testbench
======================================

Name: aes128_encrypt_core

Overview:
- Iterative AES-128 encryption engine (FIPS-197): one round per clock, round keys expanded on the fly.
- Internally it combines three datapath functions: AddRoundKey, EncryptRound (SubBytes, ShiftRows, MixColumns, AddRoundKey) and KeyExpansionRound.
- Sits beside a host that loads a 128-bit block and key, pulses start, then reads the ciphertext when done rises.

Parameters:
- NK, 4, key length in 32-bit words; only 4 (AES-128) is supported, and any other value is an elaboration error.
- NR, 10, number of rounds; must equal 10 when NK=4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin encryption; sampled only when not busy.
- data_in  input  128  plaintext block; byte 0 at bits [127:120], column-major state order.
- key  input  NK*32  cipher key, same byte order.
- data_out  output  128  state register; holds the ciphertext once done=1.
- done  output  1  ciphertext valid; level signal.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
  - On a rising edge with rst_n=0: state, round key, round counter, busy and done all clear to 0, so data_out=0 and done=0.
  - Reset mid-operation aborts the encryption with no partial result retained.
- Round counter rc: 4 bits, counts 0..NR+1 while busy.
- Edge L (start=1, busy=0): state<=data_in; keyReg<=key; rc<=1; busy<=1; done<=0.
- rc=1: state<=state^keyReg (initial AddRoundKey); keyReg<=KeyExp(keyReg, rc).
- rc=2..NR: state<=EncryptRound(state, keyReg); keyReg<=KeyExp(keyReg, rc).
- rc=NR+1: state<=LastRound(state, keyReg), which omits MixColumns; busy<=0; done<=1; keyReg is not updated.
- Latency: done rises and data_out is valid after NR+2 = 12 rising edges, counting edge L as edge 1.
- done and data_out hold until the next accepted start. That start clears done on its load edge.
- Handshake rules:
  - start while busy is ignored, and data_in/key changes while busy have no effect.
  - start held high continuously re-launches an encryption on the edge after done rises.
- KeyExp(w, r):
  - temp = SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}.
  - w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - w0 is bits [127:96].
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- MixColumns: GF(2^8) with polynomial 0x11b; xtime(b) = (b<<1) ^ (b[7]?0x1b:0).
- ShiftRows: row r is rotated left by r bytes; row r of column c is the byte at bits [127-8*(4c+r) -: 8].
- S-box: standard FIPS-197 forward table, implemented as combinational lookup. 20 S-box instances are needed (16 for the state, 4 for the key).

Decomposition:
- Package aes_pkg holds:
  - the 256-entry SBOX constant, the RCON constant and the xtime function;
  - the NK/NR legal-value constants;
  - a function sub_word(32-bit).
- One sub-module, aes_round_comb, is natural: a purely combinational block.
  - Inputs: state, round key, rc and a last-round flag.
  - Outputs: next state and next round key.
  - The top holds only registers, the counter and the handshake.

Test Plan:
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, data_in=00112233445566778899aabbccddeeff, pulse start → done after 12 edges, data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, data_in=3243f6a8885a308d313198a2e0370734 → data_out=3925841d02dc09fbdc118597196a0b32.
- All-zero key and plaintext → data_out=66e94bd4ef8a2c3b884cfa59ca342b2e.
- Busy protection: start C.1, then at edge 5 change data_in/key and re-pulse start → result still 69c4e0d8…c55a at edge 12, with no restart.
- Reset: assert rst_n=0 at edge 6 of a run → data_out=0 and done=0 on the next edge. A new start after release yields the correct App. B result with 12-edge latency.
- Back-to-back: hold start=1 with the C.1 vectors, then switch to the App. B vectors.
  - done pulses for exactly one cycle between runs.
  - The second result is 3925841d…0b32, done=1 at edge 24.
  - done stays 0 during edges 13–23.

Source files
------------

// File: rtl/aes128_encrypt_core_pkg.sv
// AES-128 constants and byte-level helpers shared by the round logic and top.
// S-box, Rcon and xtime are pure combinational lookups/functions.
package aes_pkg;

  localparam int AES_NK = 4;
  localparam int AES_NR = 10;

  typedef enum logic {ST_IDLE, ST_RUN} fsm_t;

  // Byte n of the table sits at bits [2047-8n -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Index 0 and 11..15 are unused and read as zero.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes128_encrypt_core_if.sv
// Host-side bus of the AES core: block/key load, start strobe, ciphertext and done level.
interface aes128_encrypt_core_if
  import aes_pkg::*;
#(
  parameter int NK = AES_NK
);
  logic              start;
  logic [127:0]      data_in;
  logic [NK*32-1:0]  key;
  logic [127:0]      data_out;
  logic              done;

  modport master (output start, data_in, key, input data_out, done);
  modport slave  (input start, data_in, key, output data_out, done);
endinterface

// File: rtl/aes128_encrypt_core_round.sv
// One AES round plus one key-schedule step, purely combinational.
// rc=1 selects the initial AddRoundKey; last drops MixColumns.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rkey,
  input  logic [3:0]   rc,
  input  logic         last,
  output logic [127:0] state_nxt,
  output logic [127:0] key_nxt
);

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [31:0]  temp;
  logic [31:0]  w0, w1, w2, w3;

  always_comb begin
    shifted = '0;
    mixed   = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(state[127-8*i -: 8]);
    // Byte (row r, col c) lives at index 4c+r; ShiftRows pulls from column c+r.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      shifted[127-32*c -: 32] = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
      mixed[127-32*c -: 8]  = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mixed[119-32*c -: 8]  = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mixed[111-32*c -: 8]  = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mixed[103-32*c -: 8]  = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
  end

  always_comb begin
    if (rc == 4'd1) state_nxt = state ^ rkey;
    else            state_nxt = (last ? shifted : mixed) ^ rkey;
  end

  always_comb begin
    temp = sub_word({rkey[23:0], rkey[31:24]}) ^ {RCON[rc], 24'h0};
    w0   = rkey[127:96] ^ temp;
    w1   = rkey[95:64]  ^ w0;
    w2   = rkey[63:32]  ^ w1;
    w3   = rkey[31:0]   ^ w2;
    key_nxt = {w0, w1, w2, w3};
  end

endmodule

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryptor: one round per clock, key expanded on the fly.
// Ciphertext and done appear 12 edges after the accepted start; start is ignored while busy.
module aes128_encrypt_core
  import aes_pkg::*;
#(
  parameter int NK = AES_NK,
  parameter int NR = AES_NR
) (
  input logic clk,
  input logic rst_n,
  aes128_encrypt_core_if.slave bus
);

  generate
    if (NK != AES_NK || NR != AES_NR) begin : g_bad_param
      $error("aes128_encrypt_core supports only NK=4, NR=10");
    end
  endgenerate

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rc_q, rc_d;
  logic         done_q, done_d;
  logic         last;
  logic [127:0] rnd_state, rnd_key;

  assign last = (rc_q == 4'(NR + 1));

  aes_round_comb u_round (
    .state     (state_q),
    .rkey      (key_q),
    .rc        (rc_q),
    .last      (last),
    .state_nxt (rnd_state),
    .key_nxt   (rnd_key)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      key_q   <= '0;
      rc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;
    done_d  = done_q;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = bus.data_in;
          key_d   = bus.key;
          rc_d    = 4'd1;
          done_d  = 1'b0;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = rnd_state;
        if (last) begin
          // Final key is not needed again; keep the register stable.
          rc_d   = 4'd0;
          done_d = 1'b1;
          fsm_d  = ST_IDLE;
        end else begin
          key_d = rnd_key;
          rc_d  = rc_q + 4'd1;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  assign bus.data_out = state_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Directed FIPS-197 vectors plus busy, reset and back-to-back sequences for the AES core.
module tb_aes128_encrypt_core;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  vec_t vecs [3];

  aes128_encrypt_core_if bus ();

  aes128_encrypt_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Launch one encryption and return the edge number (load edge = 1) at which done rose.
  task automatic launch(input logic [127:0] k, input logic [127:0] pt, output int lat);
    @(negedge clk);
    bus.key = k; bus.data_in = pt; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    for (int e = 2; e <= 30; e++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = e;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int hi_cnt;

    vecs[0] = '{key: C1_KEY, pt: C1_PT, ct: C1_CT};
    vecs[1] = '{key: B_KEY,  pt: B_PT,  ct: B_CT};
    vecs[2] = '{key: '0,     pt: '0,    ct: Z_CT};

    rst_n = 1'b0; bus.start = 1'b0; bus.key = '0; bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset data_out", bus.data_out, '0);
    check("reset done", 128'(bus.done), 128'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      launch(vecs[i].key, vecs[i].pt, lat);
      check($sformatf("vec%0d latency", i), 128'(lat), 128'd12);
      check($sformatf("vec%0d data_out", i), bus.data_out, vecs[i].ct);
    end

    // Busy protection: new inputs and a second start at edge 5 must be ignored.
    @(negedge clk);
    bus.key = C1_KEY; bus.data_in = C1_PT; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.key = B_KEY; bus.data_in = B_PT; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    for (int e = 6; e <= 30; e++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = e;
        break;
      end
    end
    check("busy latency", 128'(lat), 128'd12);
    check("busy data_out", bus.data_out, C1_CT);
    @(posedge clk); #1;
    check("busy done hold", 128'(bus.done), 128'd1);
    check("busy data hold", bus.data_out, C1_CT);

    // Reset at edge 6 of a run aborts it.
    @(negedge clk);
    bus.key = B_KEY; bus.data_in = B_PT; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrun reset data_out", bus.data_out, '0);
    check("midrun reset done", 128'(bus.done), 128'd0);
    rst_n = 1'b1;
    launch(B_KEY, B_PT, lat);
    check("post-reset latency", 128'(lat), 128'd12);
    check("post-reset data_out", bus.data_out, B_CT);

    // Back-to-back with start held high.
    @(negedge clk);
    bus.key = C1_KEY; bus.data_in = C1_PT; bus.start = 1'b1;
    hi_cnt = 0;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk); #1;
      if (e == 12) begin
        check("b2b first done", 128'(bus.done), 128'd1);
        check("b2b first data_out", bus.data_out, C1_CT);
        bus.key = B_KEY; bus.data_in = B_PT;
      end
      if (e == 13) check("b2b done drop", 128'(bus.done), 128'd0);
      if (e >= 13 && e <= 23 && bus.done) hi_cnt++;
      if (e == 24) begin
        check("b2b done low 13-23", 128'(hi_cnt), 128'd0);
        check("b2b second done", 128'(bus.done), 128'd1);
        check("b2b second data_out", bus.data_out, B_CT);
      end
    end
    bus.start = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
